onehot_popcnt_pipe: RTL and testbench



---
 rtl/onehot_popcnt_pkg.sv | 47 ++++
 rtl/onehot_popcnt_chunk.sv | 20 ++
 rtl/onehot_popcnt_pipe.sv | 114 +++++++++++
 tb/tb_onehot_popcnt_pipe.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/onehot_popcnt_pkg.sv
// rtl/onehot_popcnt_pkg.sv - shared constants and helper functions for the one-hot popcount pipeline
package onehot_popcnt_pkg;

  localparam int CHUNK = 6;
  // Widest intermediate one-hot: 32 padded chunks of 6 bits plus the zero-count bit.
  localparam int MAXW  = 193;

  function automatic int f_np(input int w);
    int nc;
    int np;
    nc = w / CHUNK;
    np = 1;
    while (np < nc) np = np * 2;
    return np;
  endfunction

  function automatic int f_lvl(input int w);
    int np;
    int l;
    np = f_np(w);
    l  = 0;
    while ((1 << l) < np) l++;
    return l;
  endfunction

  // Adding two counts in one-hot form is a shift of b by the index of a's set bit.
  function automatic logic [MAXW-1:0] f_combine(input logic [MAXW-1:0] a,
                                                input logic [MAXW-1:0] b,
                                                input int              aw);
    logic [MAXW-1:0] r;
    r = '0;
    for (int k = 0; k < MAXW; k++) begin
      if (k <= aw && a[k]) r = r | (b << k);
    end
    return r;
  endfunction

  function automatic logic [7:0] f_oh2bin(input logic [MAXW-1:0] oh);
    logic [7:0] r;
    r = '0;
    for (int k = 0; k < MAXW; k++) begin
      if (oh[k]) r = r | 8'(k);
    end
    return r;
  endfunction

endpackage

// File: rtl/onehot_popcnt_chunk.sv
// rtl/onehot_popcnt_chunk.sv - 6-bit chunk to 7-bit one-hot population count
module onehot_popcnt_chunk
  import onehot_popcnt_pkg::*;
(
  input  logic [CHUNK-1:0] chunk_i,
  output logic [CHUNK:0]   onehot_o
);

  logic [2:0] cnt;

  always_comb begin
    cnt = '0;
    for (int i = 0; i < CHUNK; i++) begin
      cnt = cnt + {2'b00, chunk_i[i]};
    end
    onehot_o      = '0;
    onehot_o[cnt] = 1'b1;
  end

endmodule

// File: rtl/onehot_popcnt_pipe.sv
// rtl/onehot_popcnt_pipe.sv - pipelined one-hot popcount tree with valid/ready; ONEHOT_POPCNT_BIN_EN adds out_count
module onehot_popcnt_pipe
  import onehot_popcnt_pkg::*;
#(
  parameter int W    = 24,
  parameter int TAGW = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W-1:0]    in_data,
  input  logic [TAGW-1:0] in_tag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W:0]      out_onehot,
  output logic [TAGW-1:0] out_tag
`ifdef ONEHOT_POPCNT_BIN_EN
  ,
  output logic [$clog2(W+1)-1:0] out_count
`endif
);

  localparam int NC = W / CHUNK;
  localparam int NP = f_np(W);
  localparam int L  = f_lvl(W);

  logic [L:0]           vld_q, vld_d;
  logic [L:0][TAGW-1:0] tag_q, tag_d;
  logic [L:0]           cap;
  logic [L:0]           prev_vld;
  logic [L:0][TAGW-1:0] prev_tag;

  always_comb begin
    cap      = '0;
    prev_vld = '0;
    prev_tag = '0;
    vld_d    = '0;
    tag_d    = '0;
    // A stage can capture if it or any stage downstream has room, or the output drains.
    for (int i = 0; i <= L; i++) begin
      cap[i] = out_ready;
      for (int j = i; j <= L; j++) begin
        if (!vld_q[j]) cap[i] = 1'b1;
      end
    end
    prev_vld[0] = in_valid;
    prev_tag[0] = in_tag;
    for (int i = 1; i <= L; i++) begin
      prev_vld[i] = vld_q[i-1];
      prev_tag[i] = tag_q[i-1];
    end
    for (int i = 0; i <= L; i++) begin
      vld_d[i] = cap[i] ? prev_vld[i] : vld_q[i];
      tag_d[i] = (cap[i] && prev_vld[i]) ? prev_tag[i] : tag_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      tag_q <= '0;
    end else begin
      vld_q <= vld_d;
      tag_q <= tag_d;
    end
  end

  for (genvar l = 0; l <= L; l++) begin : g_lvl
    localparam int N  = NP >> l;
    localparam int WR = (l == L) ? (W + 1) : ((CHUNK << l) + 1);

    logic [N*WR-1:0] data_q, data_d;

    if (l == 0) begin : g_leaf
      for (genvar c = 0; c < NP; c++) begin : g_chunk
        if (c < NC) begin : g_real
          onehot_popcnt_chunk u_chunk (
            .chunk_i  (in_data[c*CHUNK +: CHUNK]),
            .onehot_o (data_d[c*WR +: WR])
          );
        end else begin : g_pad
          assign data_d[c*WR +: WR] = WR'(1);
        end
      end
    end else begin : g_node
      localparam int WP = (CHUNK << (l - 1)) + 1;
      for (genvar n = 0; n < N; n++) begin : g_pair
        assign data_d[n*WR +: WR] =
          WR'(f_combine(MAXW'(g_lvl[l-1].data_q[(2*n)*WP +: WP]),
                        MAXW'(g_lvl[l-1].data_q[(2*n+1)*WP +: WP]),
                        WP - 1));
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        data_q <= '0;
      end else if (cap[l] && prev_vld[l]) begin
        data_q <= data_d;
      end
    end
  end

  assign in_ready   = cap[0];
  assign out_valid  = vld_q[L];
  assign out_tag    = tag_q[L];
  assign out_onehot = g_lvl[L].data_q;

`ifdef ONEHOT_POPCNT_BIN_EN
  assign out_count = ($clog2(W+1))'(f_oh2bin(MAXW'(out_onehot)));
`endif

endmodule

// File: tb/tb_onehot_popcnt_pipe.sv
// tb/tb_onehot_popcnt_pipe.sv - self-checking bench for onehot_popcnt_pipe (W=24 and W=18 instances)
module tb_onehot_popcnt_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [23:0] a_in_data;
  logic [3:0]  a_in_tag, a_out_tag;
  logic [24:0] a_out_onehot;
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [17:0] b_in_data;
  logic [3:0]  b_in_tag, b_out_tag;
  logic [18:0] b_out_onehot;
`ifdef ONEHOT_POPCNT_BIN_EN
  logic [4:0]  a_out_count, b_out_count;
`endif

  onehot_popcnt_pipe #(.W(24), .TAGW(4)) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_tag(a_in_tag),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_onehot(a_out_onehot), .out_tag(a_out_tag)
`ifdef ONEHOT_POPCNT_BIN_EN
    , .out_count(a_out_count)
`endif
  );

  onehot_popcnt_pipe #(.W(18), .TAGW(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_tag(b_in_tag),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_onehot(b_out_onehot), .out_tag(b_out_tag)
`ifdef ONEHOT_POPCNT_BIN_EN
    , .out_count(b_out_count)
`endif
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [23:0] data;
    logic [3:0]  tag;
    logic [24:0] exp_oh;
    int          exp_cnt;
  } vec_t;

  vec_t vecs[8];

  task automatic send_one_a(input vec_t v, input int idx);
    int lat;
    @(negedge clk);
    a_out_ready = 1'b1;
    a_in_valid  = 1'b1;
    a_in_data   = v.data;
    a_in_tag    = v.tag;
    check($sformatf("a%0d_in_ready", idx), 64'(a_in_ready), 64'(1));
    @(negedge clk);
    a_in_valid = 1'b0;
    lat = 1;
    while (!a_out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check($sformatf("a%0d_latency", idx), 64'(lat), 64'(3));
    check($sformatf("a%0d_onehot", idx), 64'(a_out_onehot), 64'(v.exp_oh));
    check($sformatf("a%0d_tag", idx), 64'(a_out_tag), 64'(v.tag));
`ifdef ONEHOT_POPCNT_BIN_EN
    check($sformatf("a%0d_count", idx), 64'(a_out_count), 64'(v.exp_cnt));
`endif
    @(negedge clk);
    check($sformatf("a%0d_drained", idx), 64'(a_out_valid), 64'(0));
  endtask

  task automatic send_one_b(input logic [17:0] d, input logic [18:0] eoh, input int idx);
    int lat;
    @(negedge clk);
    b_out_ready = 1'b1;
    b_in_valid  = 1'b1;
    b_in_data   = d;
    b_in_tag    = 4'(idx);
    @(negedge clk);
    b_in_valid = 1'b0;
    lat = 1;
    while (!b_out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check($sformatf("b%0d_latency", idx), 64'(lat), 64'(3));
    check($sformatf("b%0d_onehot", idx), 64'(b_out_onehot), 64'(eoh));
    check($sformatf("b%0d_tag", idx), 64'(b_out_tag), 64'(idx));
    @(negedge clk);
  endtask

  logic [24:0] eq[$];
  logic [3:0]  tq[$];

  initial begin
    int sent, got, first_c, last_c, acc, spurious;
    logic [23:0] d;
    logic [24:0] held_oh;

    vecs[0] = '{24'h000000, 4'd1, 25'(1) << 0,  0};
    vecs[1] = '{24'hFFFFFF, 4'd2, 25'(1) << 24, 24};
    vecs[2] = '{24'h00F00F, 4'd3, 25'(1) << 8,  8};
    vecs[3] = '{24'h000001, 4'd4, 25'(1) << 1,  1};
    vecs[4] = '{24'h800000, 4'd5, 25'(1) << 1,  1};
    vecs[5] = '{24'h111111, 4'd6, 25'(1) << 6,  6};
    vecs[6] = '{24'hA5A5A5, 4'd7, 25'(1) << 12, 12};
    vecs[7] = '{24'h07E000, 4'd8, 25'(1) << 6,  6};

    rst_n = 1'b0;
    a_in_valid = 1'b0; a_in_data = '0; a_in_tag = '0; a_out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_data = '0; b_in_tag = '0; b_out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_out_valid", 64'(a_out_valid), 64'(0));
    check("rst_out_onehot", 64'(a_out_onehot), 64'(0));
    check("rst_out_tag", 64'(a_out_tag), 64'(0));
    check("rst_b_out_valid", 64'(b_out_valid), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 64'(a_in_ready), 64'(1));

    for (int i = 0; i < 8; i++) send_one_a(vecs[i], i);

    // Back-to-back stream
    a_out_ready = 1'b1;
    sent = 0; got = 0; first_c = -1; last_c = -1; spurious = 0;
    for (int cyc = 0; cyc < 60 && got < 16; cyc++) begin
      @(negedge clk);
      if (a_out_valid) begin
        if (eq.size() == 0) spurious++;
        else begin
          check($sformatf("stream%0d_onehot", got), 64'(a_out_onehot), 64'(eq[0]));
          check($sformatf("stream%0d_tag", got), 64'(a_out_tag), 64'(tq[0]));
          void'(eq.pop_front());
          void'(tq.pop_front());
        end
        got++;
        if (first_c < 0) first_c = cyc;
        last_c = cyc;
      end
      if (sent < 16) begin
        d = 24'($urandom);
        a_in_valid = 1'b1;
        a_in_data  = d;
        a_in_tag   = sent[3:0];
        if (a_in_ready) begin
          eq.push_back(25'(1) << $countones(d));
          tq.push_back(sent[3:0]);
          sent++;
        end
      end else a_in_valid = 1'b0;
    end
    a_in_valid = 1'b0;
    check("stream_count", 64'(got), 64'(16));
    check("stream_spurious", 64'(spurious), 64'(0));
    check("stream_consecutive", 64'(last_c - first_c), 64'(15));

    // Back-pressure: consumer stalled while input keeps coming
    @(negedge clk);
    eq.delete(); tq.delete();
    a_out_ready = 1'b0;
    acc = 0;
    held_oh = '0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      if (cyc == 3) held_oh = a_out_onehot;
      d = (24'h1 << (acc + 1)) - 24'h1;
      a_in_valid = 1'b1;
      a_in_data  = d;
      a_in_tag   = 4'(8 + acc);
      if (cyc == 3) check("bp_in_ready_drop", 64'(a_in_ready), 64'(0));
      if (a_in_ready) begin
        eq.push_back(25'(1) << (acc + 1));
        tq.push_back(4'(8 + acc));
        acc++;
      end
    end
    check("bp_accepted", 64'(acc), 64'(3));
    check("bp_in_ready_low", 64'(a_in_ready), 64'(0));
    check("bp_out_stable", 64'(a_out_onehot), 64'(held_oh));
    @(negedge clk);
    a_in_valid  = 1'b0;
    a_out_ready = 1'b1;
    got = 0; spurious = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      if (a_out_valid) begin
        if (eq.size() == 0) spurious++;
        else begin
          check($sformatf("bp%0d_onehot", got), 64'(a_out_onehot), 64'(eq[0]));
          check($sformatf("bp%0d_tag", got), 64'(a_out_tag), 64'(tq[0]));
          void'(eq.pop_front());
          void'(tq.pop_front());
        end
        got++;
      end
      @(negedge clk);
    end
    check("bp_drained", 64'(got), 64'(3));
    check("bp_spurious", 64'(spurious), 64'(0));

    // Reset with two words in flight
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      a_in_valid = 1'b1;
      a_in_data  = 24'h00FFFF;
      a_in_tag   = 4'(k);
    end
    @(negedge clk);
    a_in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(a_out_valid), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    spurious = 0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(negedge clk);
      if (a_out_valid) spurious++;
    end
    check("midrst_no_stale", 64'(spurious), 64'(0));
    check("midrst_in_ready", 64'(a_in_ready), 64'(1));

    // Non-power-of-two chunk count
    send_one_b(18'h3FFFF, 19'(1) << 18, 0);
    send_one_b(18'h00000, 19'(1) << 0, 1);
    send_one_b(18'h20001, 19'(1) << 2, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
